// File: rtl/ioctl_download_router_if.sv
// Download stream from hps_io (master side) and the routed, word-packed memory writes
// produced by ioctl_download_router (slave side).
interface ioctl_download_router_if #(
    parameter int TARGETS = 4,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 16
);
    localparam int BYTES = DATA_W / 8;

    logic                ioctl_download;
    logic                ioctl_wr;
    logic [24:0]         ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic [7:0]          ioctl_index;

    logic [ADDR_W-1:0]   dn_addr;
    logic [DATA_W-1:0]   dn_data;
    logic [BYTES-1:0]    dn_be;
    logic [TARGETS-1:0]  dn_wr;
    logic                dn_busy;
    logic                core_reset_hold;
    logic [TARGETS-1:0]  dn_done;
    logic                dn_err;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  dn_addr, dn_data, dn_be, dn_wr, dn_busy, core_reset_hold, dn_done, dn_err
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output dn_addr, dn_data, dn_be, dn_wr, dn_busy, core_reset_hold, dn_done, dn_err
    );
endinterface

// File: rtl/ioctl_download_router.sv
// Routes the hps_io byte stream to one of TARGETS regions, packs bytes into DATA_W words
// and sequences the core reset hold and per-target done pulse around each download.
module ioctl_download_router #(
    parameter int TARGETS    = 4,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 16,
    parameter int RESET_HOLD = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    ioctl_download_router_if.slave  bus
);
    localparam int BYTES   = DATA_W / 8;
    localparam int LANE_W  = $clog2(BYTES);
    localparam int LANE_IW = (LANE_W > 0) ? LANE_W : 1;
    localparam int IDX_W   = (TARGETS > 1) ? $clog2(TARGETS) : 1;
    localparam int CNT_W   = $clog2(RESET_HOLD + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, HOLD, SKIP} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                err_nxt;
    logic                download_q;

    logic [DATA_W-1:0]   buf_data, buf_data_nxt;
    logic [BYTES-1:0]    buf_mask, buf_mask_nxt;
    logic [ADDR_W-1:0]   buf_addr, buf_addr_nxt;

    logic                emit;
    logic [ADDR_W-1:0]   emit_addr;
    logic [DATA_W-1:0]   emit_data;
    logic [BYTES-1:0]    emit_be;

    logic                rise, idx_ok, in_range;
    logic [IDX_W-1:0]    new_idx;
    logic [LANE_IW-1:0]  lane;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   lane_word, lane_field, merged;
    logic [BYTES-1:0]    lane_bit;
    logic [TARGETS-1:0]  onehot;

    assign rise       = bus.ioctl_download && !download_q;
    assign idx_ok     = int'(bus.ioctl_index) < TARGETS;
    assign new_idx    = IDX_W'(bus.ioctl_index);
    assign in_range   = (bus.ioctl_addr >> (ADDR_W + LANE_W)) == '0;
    assign lane       = bus.ioctl_addr[LANE_IW-1:0] & LANE_IW'(BYTES - 1);
    assign wr_addr    = ADDR_W'(bus.ioctl_addr >> LANE_W);
    assign lane_word  = DATA_W'(bus.ioctl_dout) << (8 * lane);
    assign lane_field = DATA_W'(8'hFF) << (8 * lane);
    assign merged     = (buf_data & ~lane_field) | lane_word;
    assign lane_bit   = BYTES'(1) << lane;
    assign onehot     = TARGETS'(1) << idx;

    assign bus.dn_busy         = (state == LOAD) || (state == FLUSH);
    assign bus.core_reset_hold = (state == LOAD) || (state == FLUSH) || (state == HOLD);
    assign bus.dn_done         = (state == HOLD && cnt == CNT_W'(1)) ? onehot : '0;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_nxt    = state;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        err_nxt      = bus.dn_err;
        buf_data_nxt = buf_data;
        buf_mask_nxt = buf_mask;
        buf_addr_nxt = buf_addr;
        emit         = 1'b0;
        emit_addr    = buf_addr;
        emit_data    = buf_data;
        emit_be      = buf_mask;

        unique case (state)
            IDLE: begin
                if (rise && idx_ok) begin
                    state_nxt = LOAD;
                    idx_nxt   = new_idx;
                    err_nxt   = 1'b0;
                end else if (bus.ioctl_download) begin
                    state_nxt = SKIP;
                end
            end
            LOAD: begin
                if (bus.ioctl_wr) begin
                    if (!in_range) begin
                        err_nxt = 1'b1;
                    end else if (buf_mask != '0 && (wr_addr != buf_addr || buf_mask[BYTES-1])) begin
                        // Buffered word belongs elsewhere (or is already complete): it goes out
                        // now and the new byte opens a fresh buffer, emitted on a later cycle.
                        emit         = 1'b1;
                        buf_data_nxt = lane_word;
                        buf_mask_nxt = lane_bit;
                        buf_addr_nxt = wr_addr;
                    end else if (lane == LANE_IW'(BYTES - 1)) begin
                        emit         = 1'b1;
                        emit_addr    = wr_addr;
                        emit_data    = merged;
                        emit_be      = buf_mask | lane_bit;
                        buf_data_nxt = '0;
                        buf_mask_nxt = '0;
                    end else begin
                        buf_data_nxt = merged;
                        buf_mask_nxt = buf_mask | lane_bit;
                        buf_addr_nxt = wr_addr;
                    end
                end else if (!bus.ioctl_download || buf_mask[BYTES-1]) begin
                    emit         = buf_mask != '0;
                    buf_data_nxt = '0;
                    buf_mask_nxt = '0;
                    if (!bus.ioctl_download) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = HOLD;
                cnt_nxt   = CNT_W'(RESET_HOLD);
            end
            HOLD: begin
                if (rise) begin
                    if (idx_ok) begin
                        state_nxt = LOAD;
                        idx_nxt   = new_idx;
                        err_nxt   = 1'b0;
                    end else begin
                        state_nxt = SKIP;
                    end
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SKIP: if (!bus.ioctl_download) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the edge detector keeps sampling through reset, so a download still high at
    // release is seen as level (not a rise) and the partial stream is skipped.
    always_ff @(posedge clk_sys) download_q <= bus.ioctl_download;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            buf_data    <= '0;
            buf_mask    <= '0;
            buf_addr    <= '0;
            bus.dn_wr   <= '0;
            bus.dn_addr <= '0;
            bus.dn_data <= '0;
            bus.dn_be   <= '0;
            bus.dn_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            buf_data   <= buf_data_nxt;
            buf_mask   <= buf_mask_nxt;
            buf_addr   <= buf_addr_nxt;
            bus.dn_err <= err_nxt;
            bus.dn_wr  <= emit ? onehot : '0;
            if (emit) begin
                bus.dn_addr <= emit_addr;
                bus.dn_data <= emit_data;
                bus.dn_be   <= emit_be;
            end
        end
    end
endmodule

// File: tb/tb_ioctl_download_router.sv
// Drives one download stream into a 16-bit and a 32-bit router and compares their
// strobes, hold timing, done pulses and error flag against a byte-level packing model.
module tb_ioctl_download_router;
    localparam int TARGETS = 4;
    localparam int ADDR_W  = 4;
    localparam int HOLD    = 16;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int unsigned be;
        int unsigned tgt;
    } word_t;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } byte_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl, wr;
    logic [24:0] addr;
    logic [7:0]  dout, index;

    int n_total = 0;
    int n_pass  = 0;

    byte_t stim_q[$];
    word_t got16[$], got32[$], exp16[$], exp32[$];
    bit    err_exp16, err_exp32;
    int    done_cnt16, done_cnt32, hold_cnt16, hold_cnt32;
    logic [TARGETS-1:0] done_or16, done_or32;

    ioctl_download_router_if #(.TARGETS(TARGETS), .ADDR_W(ADDR_W), .DATA_W(16)) if16 ();
    ioctl_download_router_if #(.TARGETS(TARGETS), .ADDR_W(ADDR_W), .DATA_W(32)) if32 ();

    assign if16.ioctl_download = dl;
    assign if16.ioctl_wr       = wr;
    assign if16.ioctl_addr     = addr;
    assign if16.ioctl_dout     = dout;
    assign if16.ioctl_index    = index;
    assign if32.ioctl_download = dl;
    assign if32.ioctl_wr       = wr;
    assign if32.ioctl_addr     = addr;
    assign if32.ioctl_dout     = dout;
    assign if32.ioctl_index    = index;

    ioctl_download_router #(.TARGETS(TARGETS), .ADDR_W(ADDR_W), .DATA_W(16), .RESET_HOLD(HOLD)) dut16 (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (if16.slave)
    );

    ioctl_download_router #(.TARGETS(TARGETS), .ADDR_W(ADDR_W), .DATA_W(32), .RESET_HOLD(HOLD)) dut32 (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (if32.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if16.dn_wr != '0)
            got16.push_back('{addr: 32'(if16.dn_addr), data: 32'(if16.dn_data),
                              be: 32'(if16.dn_be), tgt: 32'(if16.dn_wr)});
        if (if32.dn_wr != '0)
            got32.push_back('{addr: 32'(if32.dn_addr), data: 32'(if32.dn_data),
                              be: 32'(if32.dn_be), tgt: 32'(if32.dn_wr)});
        if (if16.dn_done != '0) begin done_cnt16++; done_or16 |= if16.dn_done; end
        if (if32.dn_done != '0) begin done_cnt32++; done_or32 |= if32.dn_done; end
        if (if16.core_reset_hold) hold_cnt16++;
        if (if32.core_reset_hold) hold_cnt32++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] pack(input word_t w);
        return {w.tgt[3:0], w.be[3:0], w.addr[23:0], w.data};
    endfunction

    task automatic push_exp(input int bpw, input word_t w);
        if (bpw == 2) exp16.push_back(w);
        else exp32.push_back(w);
    endtask

    // Byte-level packing: a word closes when its top lane arrives, when a byte for another
    // word arrives, or at download end; bytes beyond the region are dropped and flag an error.
    task automatic model_one(input int bpw, input int idx);
        word_t cur;
        bit have, err;
        int unsigned a, wa, ln;
        have = 0;
        err  = 0;
        cur  = '{addr: 0, data: 0, be: 0, tgt: 0};
        foreach (stim_q[i]) begin
            a = stim_q[i].addr;
            if (a >= (bpw << ADDR_W)) begin
                err = 1;
                continue;
            end
            wa = a / bpw;
            ln = a % bpw;
            if (have && wa != cur.addr) begin push_exp(bpw, cur); have = 0; end
            if (!have) begin cur = '{addr: wa, data: 0, be: 0, tgt: 1 << idx}; have = 1; end
            cur.data = (cur.data & ~(32'hFF << (8 * ln))) | (stim_q[i].data << (8 * ln));
            cur.be   = cur.be | (1 << ln);
            if (ln == bpw - 1) begin push_exp(bpw, cur); have = 0; end
        end
        if (have) push_exp(bpw, cur);
        if (bpw == 2) err_exp16 = err;
        else err_exp32 = err;
    endtask

    task automatic model_append(input int idx);
        model_one(2, idx);
        model_one(4, idx);
    endtask

    task automatic scenario_begin();
        got16.delete(); got32.delete(); exp16.delete(); exp32.delete(); stim_q.delete();
        done_cnt16 = 0; done_cnt32 = 0; hold_cnt16 = 0; hold_cnt32 = 0;
        done_or16 = '0; done_or32 = '0;
    endtask

    task automatic send_byte(input int unsigned a, input int unsigned d, input int gap);
        wr   = 1'b1;
        addr = 25'(a);
        dout = 8'(d);
        stim_q.push_back('{addr: a, data: d & 8'hFF});
        @(negedge clk);
        wr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic start_dl(input int idx);
        index = 8'(idx);
        dl    = 1'b1;
        @(negedge clk);
        check("start_hold16", if16.core_reset_hold, idx < TARGETS);
        check("start_busy32", if32.dn_busy, idx < TARGETS);
        if (idx < TARGETS) check("start_err16", if16.dn_err, 0);
    endtask

    task automatic cmp_q(input string tag, input word_t g[$], input word_t e[$]);
        check({tag, "/count"}, g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++)
            check({tag, "/word"}, pack(g[i]), pack(e[i]));
    endtask

    task automatic finish_dl(input string tag, input int idx, input bit valid);
        int h16, h32;
        h16 = 0;
        h32 = 0;
        if (valid) model_append(idx);
        dl = 1'b0;
        repeat (60) begin
            @(negedge clk);
            h16 += int'(if16.core_reset_hold);
            h32 += int'(if32.core_reset_hold);
        end
        check({tag, "/hold16"}, h16, valid ? HOLD + 1 : 0);
        check({tag, "/hold32"}, h32, valid ? HOLD + 1 : 0);
        check({tag, "/idle_busy"}, {if16.dn_busy, if32.dn_busy}, 0);
        cmp_q({tag, "/d16"}, got16, exp16);
        cmp_q({tag, "/d32"}, got32, exp32);
        check({tag, "/done16"}, {done_cnt16, 28'(done_or16)}, valid ? {32'd1, 28'(1 << idx)} : 64'd0);
        check({tag, "/done32"}, {done_cnt32, 28'(done_or32)}, valid ? {32'd1, 28'(1 << idx)} : 64'd0);
        check({tag, "/err16"}, if16.dn_err, err_exp16);
        check({tag, "/err32"}, if32.dn_err, err_exp32);
        if (!valid) check({tag, "/no_hold"}, hold_cnt16 + hold_cnt32, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "/wr"},   {if16.dn_wr, if32.dn_wr}, 0);
        check({tag, "/ctl"},  {if16.dn_busy, if16.core_reset_hold, if32.dn_busy, if32.core_reset_hold}, 0);
        check({tag, "/done"}, {if16.dn_done, if32.dn_done}, 0);
        check({tag, "/err"},  {if16.dn_err, if32.dn_err}, 0);
        check({tag, "/data"}, {if16.dn_data, if32.dn_data}, 0);
    endtask

    task automatic run_random(input int count);
        int idx, len, gap;
        int unsigned a;
        for (int n = 0; n < count; n++) begin
            idx = $urandom_range(0, 5);
            len = $urandom_range(1, 12);
            a   = $urandom_range(0, 40);
            scenario_begin();
            start_dl(idx);
            for (int k = 0; k < len; k++) begin
                gap = $urandom_range(0, 2);
                send_byte(a, $urandom_range(0, 255), gap);
                case ($urandom_range(0, 9))
                    0, 1:    a = $urandom_range(0, 70);
                    2:       a = (a > 0) ? a - 1 : 0;
                    default: a = a + 1;
                endcase
            end
            finish_dl("rand", idx, idx < TARGETS);
        end
    endtask

    initial begin
        rst = 1'b1; dl = 1'b0; wr = 1'b0; addr = '0; dout = '0; index = '0;
        err_exp16 = 0; err_exp32 = 0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two full 16-bit words; first strobe one cycle after the top-lane byte.
        scenario_begin();
        start_dl(1);
        send_byte(0, 8'h11, 1);
        send_byte(1, 8'h22, 0);
        check("lat_wr16",   if16.dn_wr, 4'b0010);
        check("lat_word16", {if16.dn_addr, if16.dn_data, if16.dn_be}, {4'd0, 16'h2211, 2'b11});
        check("lat_wr32",   if32.dn_wr, 4'b0000);
        @(negedge clk);
        check("strobe_1cyc", if16.dn_wr, 4'b0000);
        send_byte(2, 8'h33, 1);
        send_byte(3, 8'h44, 1);
        finish_dl("spec1", 1, 1);

        // Partial 32-bit word flushed at download end, then the timed hold and done.
        scenario_begin();
        start_dl(0);
        send_byte(0, 8'hAA, 1);
        send_byte(1, 8'hBB, 1);
        send_byte(2, 8'hCC, 1);
        finish_dl("spec2", 0, 1);

        // Word change flushes the partial word; no byte lost.
        scenario_begin();
        start_dl(3);
        send_byte(4, 8'h5C, 2);
        send_byte(9, 8'hC9, 2);
        finish_dl("spec3", 3, 1);

        // Byte beyond the 16-bit region: dropped, sticky error.
        scenario_begin();
        start_dl(0);
        send_byte(32, 8'h5A, 0);
        check("range_err16", if16.dn_err, 1);
        check("range_wr16",  if16.dn_wr, 0);
        finish_dl("range", 0, 1);

        // Unrouted index: nothing moves, error flag untouched.
        scenario_begin();
        start_dl(7);
        for (int k = 0; k < 100; k++) send_byte(k % 30, k, 0);
        finish_dl("skip", 7, 0);

        // New download during HOLD: no done for the first, hold never drops.
        scenario_begin();
        start_dl(1);
        send_byte(8, 8'h77, 1);
        send_byte(9, 8'h88, 1);
        send_byte(10, 8'h99, 1);
        model_append(1);
        stim_q.delete();
        dl = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_hold", {if16.core_reset_hold, if32.core_reset_hold}, 2'b11);
        index = 8'd2;
        dl    = 1'b1;
        @(negedge clk);
        check("abort_relaunch", {if16.dn_busy, if16.core_reset_hold, if32.dn_busy}, 3'b111);
        send_byte(0, 8'hE0, 0);
        send_byte(1, 8'hE1, 1);
        finish_dl("abort", 2, 1);

        // Reset in the middle of a download that stays high afterwards.
        scenario_begin();
        start_dl(2);
        send_byte(0, 8'h01, 1);
        send_byte(1, 8'h02, 1);
        send_byte(40, 8'h03, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_cleared("rst_mid");
        rst = 1'b0;
        scenario_begin();
        err_exp16 = 0;
        err_exp32 = 0;
        for (int k = 0; k < 10; k++) send_byte(k, 8'h80 + k, 1);
        finish_dl("rst_skip", 2, 0);

        run_random(30);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
